// File: rtl/ddr2_conv_pkg.sv
// ddr2_conv_pkg
//   Shared definitions for the user-to-MIG DDR2 bridge:
//   - one-hot FSM state encoding (WAIT_INIT, IDLE, WRITE)
//   - helpers deriving the user data width, the mask width and the
//     beat-counter width from the APP_DW / BEATS parameters.
package ddr2_conv_pkg;

  localparam logic [2:0] WAIT_INIT = 3'b001;
  localparam logic [2:0] IDLE      = 3'b010;
  localparam logic [2:0] WRITE     = 3'b100;

  // Full user word width: BEATS MIG beats side by side.
  function automatic int uw_of(input int beats, input int app_dw);
    return beats * app_dw;
  endfunction

  // One mask bit per user data byte.
  function automatic int mask_w_of(input int beats, input int app_dw);
    return (beats * app_dw) / 8;
  endfunction

  // Beat counter width; kept at least one bit so BEATS=1 still builds.
  function automatic int bcnt_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ddr2_rd_gather.sv
// ddr2_rd_gather
//   Collects BEATS MIG read beats into one user-width word. The first beat
//   lands in the most-significant slice. valid pulses for one cycle after
//   the last beat; data_o holds until the next word completes. A beat that
//   arrives while no read is outstanding is dropped and sets sticky rd_err.
// Ports:
//   CLK, RST             clock, asynchronous active-low reset
//   rd_data_valid        MIG read beat valid
//   rd_data_fifo_out     MIG read beat
//   none_pending         no read request is outstanding
//   valid, data_o        gathered word strobe and data
//   rd_err               sticky spurious-beat flag
module ddr2_rd_gather
  import ddr2_conv_pkg::*;
#(
  parameter  int APP_DW = 128,
  parameter  int BEATS  = 2,
  localparam int UW     = uw_of(BEATS, APP_DW),
  localparam int BCW    = bcnt_w_of(BEATS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rd_data_valid,
  input  logic [APP_DW-1:0] rd_data_fifo_out,
  input  logic              none_pending,
  output logic              valid,
  output logic [UW-1:0]     data_o,
  output logic              rd_err
);

  logic [UW-1:0]  gbuf_q;
  logic [BCW-1:0] gcnt_q;
  logic           take;
  logic           last;
  logic [UW-1:0]  gnext;

  assign take  = rd_data_valid & ~none_pending;
  assign last  = (gcnt_q == BCW'(BEATS - 1));
  // Earlier beats move up one slice; the new beat fills the bottom slice.
  assign gnext = (gbuf_q << APP_DW) | UW'(rd_data_fifo_out);

  // NOTE: the gather buffer is reset so an abandoned partial word can never
  // leak into the next gathered word after a mid-burst reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gbuf_q <= '0;
      gcnt_q <= '0;
      valid  <= 1'b0;
      data_o <= '0;
      rd_err <= 1'b0;
    end else begin
      valid <= take & last;
      if (rd_data_valid & none_pending) rd_err <= 1'b1;
      if (take) begin
        if (last) begin
          data_o <= gnext;
          gbuf_q <= '0;
          gcnt_q <= '0;
        end else begin
          gbuf_q <= gnext;
          gcnt_q <= gcnt_q + BCW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ddr2_convert_gen.sv
// ddr2_convert_gen
//   User-to-MIG bridge for the DDR2 application interface. One user request
//   per handshake becomes one address-FIFO command; writes are sliced into
//   BEATS write-data beats (MS slice first), reads are gathered back into one
//   user word, and a credit counter caps outstanding reads at MAX_RD.
//   All MIG-side outputs are registered (one cycle after ack).
// Build option:
//   DDR2_CONVERT_WDF_STALL_EN  when defined, write beats 1..BEATS-1 wait
//                              while app_wdf_afull is high; otherwise they
//                              are emitted on consecutive cycles regardless.
// Ports:
//   CLK, RST                   clock, asynchronous active-low reset
//   req/ack/addr/read          user request handshake (ack combinational)
//   data_i/mask                user write data and byte mask (1=masked)
//   valid/data_o               gathered read word
//   rd_pending/rd_err          outstanding reads, sticky spurious-beat flag
//   phy_init_done              MIG calibration complete
//   app_af_*                   MIG address FIFO
//   app_wdf_*                  MIG write-data FIFO
//   rd_data_valid/_fifo_out    MIG read return
module ddr2_convert_gen
  import ddr2_conv_pkg::*;
#(
  parameter  int APP_DW = 128,
  parameter  int BEATS  = 2,
  parameter  int ADDR_W = 31,
  parameter  int MAX_RD = 8,
  localparam int UW     = uw_of(BEATS, APP_DW),
  localparam int MW     = mask_w_of(BEATS, APP_DW),
  localparam int PW     = $clog2(MAX_RD + 1),
  localparam int BCW    = bcnt_w_of(BEATS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req,
  output logic                ack,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                read,
  input  logic [UW-1:0]       data_i,
  input  logic [MW-1:0]       mask,
  output logic                valid,
  output logic [UW-1:0]       data_o,
  output logic [PW-1:0]       rd_pending,
  output logic                rd_err,
  input  logic                phy_init_done,
  output logic                app_af_wren,
  input  logic                app_af_afull,
  output logic [ADDR_W-1:0]   app_af_addr,
  output logic                app_af_read,
  output logic                app_wdf_wren,
  input  logic                app_wdf_afull,
  output logic [APP_DW-1:0]   app_wdf_data,
  output logic [APP_DW/8-1:0] app_wdf_mask_data,
  input  logic                rd_data_valid,
  input  logic [APP_DW-1:0]   rd_data_fifo_out
);

  localparam int BMW = APP_DW / 8;

  logic [2:0]     state;
  logic [UW-1:0]  wdata_q;
  logic [MW-1:0]  wmask_q;
  logic [BCW-1:0] wbeat_q;
  logic           wr_emit;
  logic           wr_last;
  logic           rd_ack;
  logic           wr_ack;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ack = 1'b0;
    if (state == IDLE)
      ack = req & ~app_af_afull & ~app_wdf_afull &
            (~read | (rd_pending < PW'(MAX_RD)));
  end

  assign rd_ack = ack & read;
  assign wr_ack = ack & ~read;

`ifdef DDR2_CONVERT_WDF_STALL_EN
  assign wr_emit = (state == WRITE) & ~app_wdf_afull;
`else
  assign wr_emit = (state == WRITE);
`endif

  assign wr_last = (wbeat_q == BCW'(BEATS - 1));

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state             <= WAIT_INIT;
      app_af_wren       <= 1'b0;
      app_af_addr       <= '0;
      app_af_read       <= 1'b0;
      app_wdf_wren      <= 1'b0;
      app_wdf_data      <= '0;
      app_wdf_mask_data <= '0;
      wdata_q           <= '0;
      wmask_q           <= '0;
      wbeat_q           <= '0;
    end else begin
      app_af_wren  <= ack;
      app_wdf_wren <= wr_ack | wr_emit;
      if (ack) begin
        app_af_addr <= addr;
        app_af_read <= read;
      end
      case (state)
        WAIT_INIT: if (phy_init_done) state <= IDLE;
        IDLE: begin
          if (wr_ack) begin
            // Beat 0 goes out with the command; the rest is kept pre-shifted
            // so the next beat is always the top slice of the holding reg.
            app_wdf_data      <= data_i[UW-1 -: APP_DW];
            app_wdf_mask_data <= mask[MW-1 -: BMW];
            wdata_q           <= data_i << APP_DW;
            wmask_q           <= mask << BMW;
            wbeat_q           <= BCW'(1);
            if (BEATS > 1) state <= WRITE;
          end
        end
        WRITE: begin
          if (wr_emit) begin
            app_wdf_data      <= wdata_q[UW-1 -: APP_DW];
            app_wdf_mask_data <= wmask_q[MW-1 -: BMW];
            wdata_q           <= wdata_q << APP_DW;
            wmask_q           <= wmask_q << BMW;
            if (wr_last) begin
              wbeat_q <= '0;
              state   <= IDLE;
            end else begin
              wbeat_q <= wbeat_q + BCW'(1);
            end
          end
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

  // Read credits: a read ack and a completed word in the same cycle cancel.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_pending <= '0;
    end else begin
      case ({rd_ack, valid})
        2'b10:   rd_pending <= rd_pending + PW'(1);
        2'b01:   rd_pending <= rd_pending - PW'(1);
        default: rd_pending <= rd_pending;
      endcase
    end
  end

  ddr2_rd_gather #(
    .APP_DW (APP_DW),
    .BEATS  (BEATS)
  ) u_gather (
    .CLK              (CLK),
    .RST              (RST),
    .rd_data_valid    (rd_data_valid),
    .rd_data_fifo_out (rd_data_fifo_out),
    .none_pending     (rd_pending == '0),
    .valid            (valid),
    .data_o           (data_o),
    .rd_err           (rd_err)
  );

endmodule
